// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} piso_state_t;

  localparam int DEFAULT_WIDTH = 9;
  localparam int GAP_W         = 4;

endpackage

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: valid/ready word input, MSB-first serial
// output with bit-valid strobe and first/last framing, one-word holding register.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] pi_data,
  input  logic             pi_valid,
  output logic             pi_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_first,
  output logic             so_last,
  output logic             busy
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  TOP_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  piso_state_t      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [GAP_W-1:0] gapcnt_q, gapcnt_d;

  logic so_q, so_d;
  logic so_valid_q, so_valid_d;
  logic so_first_q, so_first_d;
  logic so_last_q, so_last_d;
  logic busy_q, busy_d;

  logic accept;
  logic word_done;
  logic load_slot;

  assign pi_ready = !hold_full_q && !clear;
  assign accept   = pi_valid && pi_ready;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bitcnt_q    <= '0;
      gapcnt_q    <= '0;
      so_q        <= 1'b0;
      so_valid_q  <= 1'b0;
      so_first_q  <= 1'b0;
      so_last_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bitcnt_q    <= bitcnt_d;
      gapcnt_q    <= gapcnt_d;
      so_q        <= so_d;
      so_valid_q  <= so_valid_d;
      so_first_q  <= so_first_d;
      so_last_q   <= so_last_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bitcnt_d    = bitcnt_q;
    gapcnt_d    = gapcnt_q;
    word_done   = (state_q == SHIFT) && (bitcnt_q == '0);
    // Edges where the shifter is free: a waiting word wins, else a fresh accept loads directly.
    load_slot   = (state_q == IDLE) || (word_done && (GAP_CYCLES == 0)) ||
                  ((state_q == GAP) && (gapcnt_q == GAP_LAST));
    if (load_slot) begin
      if (hold_full_q) begin
        shreg_d     = hold_q;
        hold_full_d = 1'b0;
        bitcnt_d    = TOP_BIT;
        state_d     = SHIFT;
      end else if (accept) begin
        shreg_d  = pi_data;
        bitcnt_d = TOP_BIT;
        state_d  = SHIFT;
      end else begin
        shreg_d  = '0;
        bitcnt_d = '0;
        state_d  = IDLE;
      end
    end else begin
      if (accept) begin
        hold_d      = pi_data;
        hold_full_d = 1'b1;
      end
      case (state_q)
        SHIFT: begin
          if (word_done) begin
            state_d  = GAP;
            gapcnt_d = '0;
            shreg_d  = '0;
          end else begin
            shreg_d  = shreg_q << 1;
            bitcnt_d = bitcnt_q - CNT_W'(1);
          end
        end
        GAP:     gapcnt_d = gapcnt_q + GAP_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    so_d       = 1'b0;
    so_valid_d = 1'b0;
    so_first_d = 1'b0;
    so_last_d  = 1'b0;
    busy_d     = (state_d != IDLE) || hold_full_d;
    if (state_d == SHIFT) begin
      so_d       = shreg_d[WIDTH-1];
      so_valid_d = 1'b1;
      so_first_d = (bitcnt_d == TOP_BIT);
      so_last_d  = (bitcnt_d == '0);
    end
  end

  assign so       = so_q;
  assign so_valid = so_valid_q;
  assign so_first = so_first_q;
  assign so_last  = so_last_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: two instances (no gap, 3-cycle gap) against a
// word-schedule model, plus literal checks on recorded output traces.
module tb_piso_tx;

  localparam int W  = 9;
  localparam int TN = 4096;

  logic         clk;
  logic         clear;
  logic [W-1:0] pi_data;
  logic         pi_valid;
  logic         pi_ready [2];
  logic         so [2], so_valid [2], so_first [2], so_last [2], busy [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic chk_en;

  logic tr_v [2][TN];
  logic tr_s [2][TN];
  logic tr_f [2][TN];
  logic tr_l [2][TN];
  logic tr_r [2][TN];
  logic tr_b [2][TN];

  piso_tx #(.WIDTH(W), .GAP_CYCLES(0)) u_g0 (
    .clk(clk), .clear(clear), .pi_data(pi_data), .pi_valid(pi_valid),
    .pi_ready(pi_ready[0]), .so(so[0]), .so_valid(so_valid[0]),
    .so_first(so_first[0]), .so_last(so_last[0]), .busy(busy[0]));

  piso_tx #(.WIDTH(W), .GAP_CYCLES(3)) u_g3 (
    .clk(clk), .clear(clear), .pi_data(pi_data), .pi_valid(pi_valid),
    .pi_ready(pi_ready[1]), .so(so[1]), .so_valid(so_valid[1]),
    .so_first(so_first[1]), .so_last(so_last[1]), .busy(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Model: each accepted word gets a start cycle = max(accept edge, previous last bit + gap + 1).
  int          n_w   [2];
  int          w_e   [2][4];
  int          w_s   [2][4];
  logic [W-1:0] w_d  [2][4];
  int          lastl [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      n_w[i]   = 0;
      lastl[i] = -1000;
    end
  end

  always @(negedge clk) begin : model
    int   c, s, l, g, k2;
    logic ev, eso, ef, el, eb, pend, er;
    c = cyc;
    for (int i = 0; i < 2; i++) begin
      g = gap_of(i);
      if (c < TN) begin
        tr_v[i][c] = so_valid[i]; tr_s[i][c] = so[i]; tr_f[i][c] = so_first[i];
        tr_l[i][c] = so_last[i];  tr_r[i][c] = pi_ready[i]; tr_b[i][c] = busy[i];
      end
      if (chk_en) begin
        ev = 0; eso = 0; ef = 0; el = 0; eb = 0; pend = 0;
        for (int k = 0; k < n_w[i]; k++) begin
          s = w_s[i][k];
          l = s + W - 1;
          if (c >= s && c <= l) begin
            ev  = 1;
            eso = w_d[i][k][W-1-(c-s)];
            ef  = (c == s);
            el  = (c == l);
          end
          if (c >= w_e[i][k] && c <= l + g) eb = 1;
          if (c >= w_e[i][k] && c < s) pend = 1;
        end
        er = !clear && !pend;
        chk($sformatf("so_valid[%0d]@%0d", i, c), so_valid[i], ev);
        chk($sformatf("so[%0d]@%0d", i, c), so[i], eso);
        chk($sformatf("so_first[%0d]@%0d", i, c), so_first[i], ef);
        chk($sformatf("so_last[%0d]@%0d", i, c), so_last[i], el);
        chk($sformatf("busy[%0d]@%0d", i, c), busy[i], eb);
        chk($sformatf("pi_ready[%0d]@%0d", i, c), pi_ready[i], er);
        if (clear) begin
          n_w[i]   = 0;
          lastl[i] = -1000;
        end else begin
          k2 = 0;
          for (int k = 0; k < n_w[i]; k++) begin
            if (w_s[i][k] + W - 1 + g >= c) begin
              w_e[i][k2] = w_e[i][k]; w_s[i][k2] = w_s[i][k]; w_d[i][k2] = w_d[i][k];
              k2++;
            end
          end
          n_w[i] = k2;
          if (pi_valid && er && n_w[i] < 4) begin
            s = (c + 1 > lastl[i] + g + 1) ? c + 1 : lastl[i] + g + 1;
            w_e[i][n_w[i]] = c + 1;
            w_s[i][n_w[i]] = s;
            w_d[i][n_w[i]] = pi_data;
            n_w[i]++;
            lastl[i] = s + W - 1;
          end
        end
      end
    end
  end

  function automatic logic [W-1:0] word_at(input int i, input int a);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < W; k++) w = {w[W-2:0], tr_s[i][a+k]};
    return w;
  endfunction

  function automatic int count_of(input int sel, input int i, input int lo, input int hi);
    int n;
    n = 0;
    for (int c = lo; c <= hi; c++) begin
      case (sel)
        0: n += int'(tr_v[i][c]);
        1: n += int'(tr_f[i][c]);
        2: n += int'(tr_l[i][c]);
        default: n += int'(tr_r[i][c]);
      endcase
    end
    return n;
  endfunction

  int r0, a, p;

  initial begin
    clear = 1'b1; pi_valid = 1'b0; pi_data = '0; chk_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 clear = 1'b0; chk_en = 1'b1;
    r0 = cyc;
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("idle_ready[%0d]", i), count_of(3, i, r0, r0 + 19), 20);
      chk($sformatf("idle_valid[%0d]", i), count_of(0, i, r0, r0 + 19), 0);
    end

    // single word
    a = cyc + 1;
    pi_valid = 1'b1; pi_data = 9'b101100111;
    @(posedge clk); #1 pi_valid = 1'b0; pi_data = '0;
    repeat (20) @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("single_word[%0d]", i), word_at(i, a), 9'b101100111);
      chk($sformatf("single_pre_valid[%0d]", i), tr_v[i][a-1], 1'b0);
      chk($sformatf("single_first[%0d]", i), count_of(1, i, a - 1, a + 9) * 100 + int'(tr_f[i][a]), 101);
      chk($sformatf("single_last[%0d]", i), count_of(2, i, a - 1, a + 9) * 100 + int'(tr_l[i][a+8]), 101);
      chk($sformatf("single_post_valid[%0d]", i), tr_v[i][a+9], 1'b0);
      chk($sformatf("single_busy_end[%0d]", i), tr_b[i][a+12], 1'b0);
    end

    // back-to-back / gap
    a = cyc + 1;
    pi_valid = 1'b1; pi_data = 9'h167;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1 pi_data = 9'h0A5;
    end
    @(posedge clk); #1 pi_valid = 1'b0; pi_data = '0;
    repeat (40) @(posedge clk); #1;
    chk("b2b_word0", word_at(0, a), 9'h167);
    chk("b2b_word1", word_at(0, a + 9), 9'h0A5);
    chk("b2b_valid_run", count_of(0, 0, a, a + 17), 18);
    chk("b2b_firsts", count_of(1, 0, a, a + 17) * 100 + int'(tr_f[0][a]) * 10 + int'(tr_f[0][a+9]), 211);
    chk("b2b_ready", int'(tr_r[0][a]) * 100 + count_of(3, 0, a + 1, a + 8) * 10 + int'(tr_r[0][a+9]), 101);
    chk("gap_word0", word_at(1, a), 9'h167);
    chk("gap_idle_valid", count_of(0, 1, a + 9, a + 11), 0);
    chk("gap_idle_so", int'(tr_s[1][a+9]) + int'(tr_s[1][a+10]) + int'(tr_s[1][a+11]), 0);
    chk("gap_first", tr_f[1][a+12], 1'b1);
    chk("gap_word1", word_at(1, a + 12), 9'h0A5);

    // backpressure with toggling data
    a = cyc + 1;
    pi_valid = 1'b1; pi_data = 9'h1C3;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1 pi_data = (k % 2 == 0) ? 9'h0F0 : 9'h10F;
    end
    @(posedge clk); #1 pi_valid = 1'b0; pi_data = '0;
    repeat (40) @(posedge clk); #1;
    chk("bp_word0", word_at(0, a), 9'h1C3);
    chk("bp_word1", word_at(0, a + 9), 9'h0F0);
    chk("bp_word2", word_at(0, a + 18), 9'h10F);

    // mid-word clear with a pending word
    p = cyc;
    pi_valid = 1'b1; pi_data = 9'h1FF;
    @(posedge clk); #1 pi_data = 9'h055;
    @(posedge clk); #1 pi_valid = 1'b0; pi_data = '0;
    repeat (3) @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    repeat (25) @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("clr_bits_before[%0d]", i), count_of(0, i, p + 1, p + 5), 5);
      chk($sformatf("clr_after[%0d]", i),
          {tr_v[i][p+6], tr_s[i][p+6], tr_f[i][p+6], tr_l[i][p+6], tr_b[i][p+6], tr_r[i][p+6]}, 6'b000001);
      chk($sformatf("clr_no_last[%0d]", i), count_of(2, i, p + 1, p + 25), 0);
      chk($sformatf("clr_no_resend[%0d]", i), count_of(0, i, p + 6, p + 25), 0);
    end

    // random traffic with occasional clear
    for (int blk = 0; blk < 30; blk++) begin
      int dens;
      dens = $urandom_range(1, 4);
      for (int k = 0; k < 100; k++) begin
        @(posedge clk); #1;
        clear    = ($urandom_range(0, 199) == 0);
        pi_valid = ($urandom_range(0, 3) < dens);
        pi_data  = W'($urandom);
      end
    end
    @(posedge clk); #1 clear = 1'b0; pi_valid = 1'b0;
    repeat (40) @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
